// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched IF/IE registers, IME tracking with EI delay,
// dispatch handshake with the Sequencer and late vector resolution.
module irq_arbiter #(
    parameter int unsigned NUM_SRC    = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter logic [7:0]  VEC_STRIDE = 8'h08
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in_i,
    input  logic               reg_wr_i,
    input  logic               reg_rd_i,
    input  logic               reg_sel_i,
    input  logic [7:0]         reg_din_i,
    output logic [7:0]         reg_dout_o,
    input  logic               ei_i,
    input  logic               di_i,
    input  logic               reti_i,
    input  logic               insn_end_i,
    output logic               int_req_o,
    input  logic               int_ack_i,
    input  logic               vec_sample_i,
    output logic [7:0]         vec_o,
    output logic               vec_valid_o,
    output logic               ime_o,
    output logic               wake_o
);

    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_STACK = 2'd2,
        S_VECT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_SRC-1:0] irq_q;
    logic               ime_q, ime_d;
    logic               ime_pend_q, ime_pend_d;
    logic               int_req_q, int_req_d;
    logic [7:0]         vec_q, vec_d;
    logic               vec_valid_q, vec_valid_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] hit;
    logic [NUM_SRC-1:0] clr_mask;
    logic               pend;
    logic               win;
    logic [IDX_W-1:0]   win_idx;
    logic               ack_take;
    logic [7:0]         if_rd;

    assign rise     = irq_in_i & ~irq_q;
    assign hit      = if_q & ie_q[NUM_SRC-1:0];
    assign pend     = |hit;
    assign ack_take = (state_q == S_REQ) && int_ack_i;

    // Lowest-index pending and enabled source wins.
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win     = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    // Dispatch state machine; vector resolved from the live IF/IE at VEC_SAMPLE.
    always_comb begin
        state_d     = state_q;
        clr_mask    = '0;
        vec_d       = vec_q;
        case (state_q)
            S_IDLE: begin
                if (ime_q && pend) state_d = S_REQ;
            end
            S_REQ: begin
                if (int_ack_i)             state_d = S_STACK;
                else if (!(ime_q && pend)) state_d = S_IDLE;
            end
            S_STACK: begin
                if (vec_sample_i) begin
                    state_d = S_VECT;
                    if (win) begin
                        vec_d             = 8'(VEC_BASE + 8'(win_idx) * VEC_STRIDE);
                        clr_mask[win_idx] = 1'b1;
                    end else begin
                        vec_d = 8'h00;
                    end
                end
            end
            S_VECT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        int_req_d   = (state_d == S_REQ);
        vec_valid_d = (state_d == S_VECT);
    end

    // IF/IE next state: rising edge beats CPU write beats dispatch clear.
    always_comb begin
        if_d = if_q & ~clr_mask;
        ie_d = ie_q;
        if (reg_wr_i && !reg_sel_i) if_d = reg_din_i[NUM_SRC-1:0];
        if (reg_wr_i && reg_sel_i)  ie_d = reg_din_i;
        if_d = if_d | rise;
    end

    // Master enable: EI arms a pending enable taken at a later boundary; DI dominates.
    always_comb begin
        ime_d      = ime_q;
        ime_pend_d = ime_pend_q;
        if (insn_end_i && ime_pend_q) begin
            ime_d      = 1'b1;
            ime_pend_d = 1'b0;
        end
        if (ei_i && (state_q != S_STACK)) ime_pend_d = 1'b1;
        if (reti_i) ime_d = 1'b1;
        if (ack_take || di_i) begin
            ime_d      = 1'b0;
            ime_pend_d = 1'b0;
        end
    end

    // State and register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            if_q        <= '0;
            ie_q        <= '0;
            irq_q       <= '0;
            ime_q       <= 1'b0;
            ime_pend_q  <= 1'b0;
            int_req_q   <= 1'b0;
            vec_q       <= 8'h00;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_q        <= if_d;
            ie_q        <= ie_d;
            irq_q       <= irq_in_i;
            ime_q       <= ime_d;
            ime_pend_q  <= ime_pend_d;
            int_req_q   <= int_req_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    // Register read mux; unused IF bits read as one.
    always_comb begin
        if_rd              = 8'hFF;
        if_rd[NUM_SRC-1:0] = if_q;
        reg_dout_o         = 8'h00;
        if (reg_rd_i) reg_dout_o = reg_sel_i ? ie_q : if_rd;
    end

    assign int_req_o   = int_req_q;
    assign vec_o       = vec_q;
    assign vec_valid_o = vec_valid_q;
    assign ime_o       = ime_q;
    assign wake_o      = pend;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter.
module tb_irq_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] irq_in;
    logic       reg_wr, reg_rd, reg_sel;
    logic [7:0] reg_din;
    logic [7:0] reg_dout;
    logic       ei, di, reti, insn_end;
    logic       int_req, int_ack, vec_sample;
    logic [7:0] vec;
    logic       vec_valid, ime, wake;

    int tests  = 0;
    int failed = 0;

    irq_arbiter #(.NUM_SRC(5), .VEC_BASE(8'h40), .VEC_STRIDE(8'h08)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in_i     (irq_in),
        .reg_wr_i     (reg_wr),
        .reg_rd_i     (reg_rd),
        .reg_sel_i    (reg_sel),
        .reg_din_i    (reg_din),
        .reg_dout_o   (reg_dout),
        .ei_i         (ei),
        .di_i         (di),
        .reti_i       (reti),
        .insn_end_i   (insn_end),
        .int_req_o    (int_req),
        .int_ack_i    (int_ack),
        .vec_sample_i (vec_sample),
        .vec_o        (vec),
        .vec_valid_o  (vec_valid),
        .ime_o        (ime),
        .wake_o       (wake)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic sel, input logic [7:0] d);
        reg_wr = 1'b1; reg_sel = sel; reg_din = d;
        tick();
        reg_wr = 1'b0; reg_sel = 1'b0; reg_din = 8'h00;
    endtask

    task automatic rd(input logic sel, input logic [7:0] exp, input string tag);
        reg_rd = 1'b1; reg_sel = sel;
        #1;
        check(tag, reg_dout, exp);
        reg_rd = 1'b0; reg_sel = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1; tick(); reti = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; reg_wr = 0; reg_rd = 0; reg_sel = 0; reg_din = 0;
        ei = 0; di = 0; reti = 0; insn_end = 0; int_ack = 0; vec_sample = 0;
        #3;
        check("rst_int_req", 8'(int_req), 8'h00);
        check("rst_vec", vec, 8'h00);
        check("rst_vec_valid", 8'(vec_valid), 8'h00);
        check("rst_ime", 8'(ime), 8'h00);
        check("rst_dout_idle", reg_dout, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        tick();
        rd(0, 8'hE0, "rst_if");
        rd(1, 8'h00, "rst_ie");

        // Edge on source 2 with IME off: wake only.
        wr(1, 8'h04);
        irq_in = 5'h04; tick(); irq_in = 5'h00;
        check("wake_edge", 8'(wake), 8'h01);
        rd(0, 8'hE4, "if_src2");
        tick(); tick();
        check("no_req_ime0", 8'(int_req), 8'h00);
        wr(0, 8'h00);
        #1 check("wake_cleared", 8'(wake), 8'h00);

        // Sources 3 and 1 together, EI delay, dispatch of source 1.
        wr(1, 8'h1F);
        irq_in = 5'h0A; tick(); irq_in = 5'h00;
        rd(0, 8'hEA, "if_src31");
        ei = 1; tick(); ei = 0;
        check("ei_delay", 8'(ime), 8'h00);
        insn_end = 1; tick(); insn_end = 0;
        check("ime_after_insn_end", 8'(ime), 8'h01);
        check("req_not_yet", 8'(int_req), 8'h00);
        tick();
        check("req_up", 8'(int_req), 8'h01);
        int_ack = 1; tick(); int_ack = 0;
        check("ack_ime_clr", 8'(ime), 8'h00);
        check("ack_req_clr", 8'(int_req), 8'h00);
        vec_sample = 1; tick(); vec_sample = 0;
        check("vec_src1", vec, 8'h48);
        check("vv_src1", 8'(vec_valid), 8'h01);
        rd(0, 8'hE8, "if_after_src1");
        tick();
        check("vv_one_cycle", 8'(vec_valid), 8'h00);
        check("vec_hold", vec, 8'h48);
        tick();
        check("no_req_after", 8'(int_req), 8'h00);

        // EI then DI before the boundary: IME never rises.
        ei = 1; tick(); ei = 0;
        di = 1; tick(); di = 0;
        insn_end = 1; tick(); insn_end = 0;
        check("ei_di_ime", 8'(ime), 8'h00);
        tick(); tick();
        check("ei_di_noreq", 8'(int_req), 8'h00);

        // RETI enables immediately; DI withdraws the request.
        pulse_reti();
        check("reti_ime", 8'(ime), 8'h01);
        tick();
        check("reti_req", 8'(int_req), 8'h01);
        di = 1; tick(); di = 0;
        tick();
        check("di_drops_req", 8'(int_req), 8'h00);
        wr(0, 8'h00);

        // Cancelled dispatch: IE cleared between ACK and VEC_SAMPLE.
        wr(1, 8'h01);
        wr(0, 8'h01);
        pulse_reti();
        tick();
        check("cancel_req", 8'(int_req), 8'h01);
        int_ack = 1; tick(); int_ack = 0;
        wr(1, 8'h00);
        vec_sample = 1; tick(); vec_sample = 0;
        check("cancel_vec", vec, 8'h00);
        check("cancel_vv", 8'(vec_valid), 8'h01);
        rd(0, 8'hE1, "cancel_if");
        tick();

        // Rising edge beats CPU write beats dispatch clear on bit 0.
        wr(1, 8'h01);
        pulse_reti();
        tick();
        int_ack = 1; tick(); int_ack = 0;
        vec_sample = 1; irq_in = 5'h01; reg_wr = 1; reg_sel = 0; reg_din = 8'h00;
        tick();
        vec_sample = 0; reg_wr = 0; reg_din = 8'h00;
        check("prio_vec", vec, 8'h40);
        rd(0, 8'hE1, "prio_if");
        // Held line does not re-set IF after clearing.
        wr(0, 8'h00);
        tick(); tick();
        rd(0, 8'hE0, "held_no_reset");
        irq_in = 5'h00;
        tick();

        // Reset in the middle of STACK.
        irq_in = 5'h01; tick(); irq_in = 5'h00;
        pulse_reti();
        tick();
        int_ack = 1; tick(); int_ack = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 8'(int_req), 8'h00);
        check("mid_rst_ime", 8'(ime), 8'h00);
        rd(0, 8'hE0, "mid_rst_if");
        rd(1, 8'h00, "mid_rst_ie");
        vec_sample = 1; tick(); vec_sample = 0;
        check("mid_rst_vv", 8'(vec_valid), 8'h00);
        rst_n = 1'b1;
        tick();
        check("post_rst_vv", 8'(vec_valid), 8'h00);

        // Fresh dispatch after release (source 4, vector 0x60).
        wr(1, 8'h10);
        irq_in = 5'h10; tick(); irq_in = 5'h00;
        pulse_reti();
        tick();
        check("fresh_req", 8'(int_req), 8'h01);
        int_ack = 1; tick(); int_ack = 0;
        vec_sample = 1; tick(); vec_sample = 0;
        check("fresh_vec", vec, 8'h60);
        check("fresh_vv", 8'(vec_valid), 8'h01);
        rd(0, 8'hE0, "fresh_if");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt arbiter and dispatch scheduler in front of the CPU core's Sequencer. It latches edge-triggered requests from up to five peripheral sources into an IF register and masks them with an IE register. It tracks the master enable IME, including the one-instruction EI delay. It asks the Sequencer for a dispatch slot at an instruction boundary and resolves the winning vector late, during the stacking phase, so a request withdrawn mid-dispatch yields the cancelled vector 0x00. It also drives the Sequencer WAKE input out of HALT/STOP.

## Interface
- NUM_SRC, 5, number of interrupt sources (1..8); bit 0 is the highest priority
- VEC_BASE, 8'h40, vector of source 0
- VEC_STRIDE, 8'h08, vector spacing between adjacent sources
- CLK  in  1  core clock; all state updates on rising edge
- nRESET  in  1  reset, asynchronous, active-low
- IRQ_IN  in  NUM_SRC  peripheral request lines; a rising edge (0 in previous cycle, 1 now) sets the matching IF bit
- REG_WR, REG_RD  in  1  CPU register strobe, one cycle
- REG_SEL  in  1  register select: 0 = IF, 1 = IE
- REG_DIN  in  8  write data
- REG_DOUT  out  8  read data, combinational, valid while REG_RD
- EI, DI, RETI  in  1  decoder pulses, one cycle
- INSN_END  in  1  instruction boundary pulse from the Sequencer
- INT_REQ  out  1  dispatch request to the Sequencer
- INT_ACK  in  1  Sequencer accepts the dispatch; honoured only while INT_REQ = 1
- VEC_SAMPLE  in  1  Sequencer stacking phase done; resolve the vector now
- VEC  out  8  dispatch vector
- VEC_VALID  out  1  one-cycle strobe qualifying VEC
- IME  out  1  current master enable
- WAKE  out  1  combinational: |(IF & IE[NUM_SRC-1:0]); ignores IME

## Operation
- Reset values:
  - IF = 0; IE = 0; IME = 0; ime_pend = 0; IRQ_IN history = 0.
  - INT_REQ = 0; VEC = 0x00; VEC_VALID = 0; state = IDLE.
  - REG_DOUT = 0x00 when idle.
- IF read:
  - bits [NUM_SRC-1:0] = IF.
  - unused upper bits read 1; reset IF reads 0xE0 for NUM_SRC=5.
- IE: full 8-bit read/write register.
- IF write: loads REG_DIN[NUM_SRC-1:0].
- IF bit update priority, per bit, same cycle: rising-edge set > CPU write > dispatch clear.
- IME control:
  - DI clears IME and ime_pend immediately.
  - EI sets ime_pend; IME becomes 1 at the first INSN_END strictly after the EI cycle.
  - RETI sets IME immediately.
  - If EI and DI occur in the same cycle, DI wins.
- pend = |(IF & IE[NUM_SRC-1:0]).
- State machine:
  - IDLE -> REQ when IME & pend; INT_REQ = 1 in REQ.
  - REQ -> IDLE if IME drops or pend drops before INT_ACK; INT_REQ deasserts.
  - REQ -> STACK on INT_ACK. On that edge, IME is cleared and ime_pend is cleared.
  - STACK waits for VEC_SAMPLE; INT_ACK and EI are ignored in STACK.
  - On VEC_SAMPLE, the winner is the lowest index i with IF[i] & IE[i].
  - Winner found: VEC = VEC_BASE + i*VEC_STRIDE (8-bit, wraps mod 256), and IF[i] is cleared.
  - No winner: VEC = 0x00 and no IF bit changes (cancelled dispatch).
  - STACK -> VECT. In VECT, VEC_VALID = 1 for one cycle, then -> IDLE. VEC holds its value until the next VECT.

## Timing
- Edge-to-WAKE: IRQ_IN rises in cycle n -> IF bit set at the end of n -> WAKE high in n+1, provided the IE bit is set.
- INT_REQ is registered: the condition true in cycle n -> INT_REQ high in n+1.
- INT_ACK sampled in cycle n -> state STACK and IME = 0 from n+1.
- VEC_SAMPLE in cycle m -> VEC and VEC_VALID valid in m+1.
- Minimum dispatch from ACK is 2 cycles. The arbiter accepts VEC_SAMPLE as early as the cycle after ACK.
- A CPU write to IE or IF between ACK and VEC_SAMPLE takes part in the late resolution. This is what makes cancellation possible.
- nRESET low in any state: immediately forces the reset values, including mid-STACK and mid-VECT; no VEC_VALID is emitted. Operation resumes from IDLE on the first edge after release.
- IRQ_IN held high does not re-set IF after it is cleared; a new rising edge is required.

## Test plan
- Reset, then read IF and IE -> 0xE0 and 0x00. Pulse IRQ_IN[2] with IE=0x04 and IME=0 -> WAKE=1, INT_REQ stays 0.
- IE=0x1F; IRQ_IN[3] and IRQ_IN[1] rise together; EI, then INSN_END -> IME=1 one cycle after INSN_END. INT_REQ rises. After ACK and VEC_SAMPLE -> VEC=0x48, IF=0xE8 (bit 3 left pending), IME=0.
- EI then DI before INSN_END -> IME stays 0 and INT_REQ never asserts.
- IF=0x01, IE=0x01, IME=1, ACK. Write IE=0x00 before VEC_SAMPLE -> VEC=0x00, VEC_VALID pulse, IF still 0xE1.
- Same cycle: IRQ_IN[0] rising edge, CPU write IF=0x00, and dispatch clear of bit 0 -> IF bit 0 = 1. Separately, RETI -> IME=1 in the next cycle.
- Drop nRESET mid-STACK -> INT_REQ=0, no VEC_VALID, IF=0xE0, IE=0x00, IME=0. After release, a fresh request dispatches normally.
